mux16_arbiter: RTL and testbench
================================

Name: mux16_arbiter

Overview:
Two-requester round-robin arbiter that shares a single 16-bit 2:1 word mux between source A and source B. It owns the mux select and the per-port valid/ready handshakes, and registers the chosen word into a one-entry output stage. Consumers downstream see a single valid/ready stream. A burst limit bounds how long one port can hold the mux while the other port is waiting.

Parameters:
WIDTH, 16, data word width; mux width, fixed at 16 in this design
MAX_BURST, 4, maximum consecutive beats one port may transfer while the other port is requesting (>=1)
CNT_W, 3, burst counter width; must hold MAX_BURST

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
a_valid  in  1  port A has a word
a_data  in  16  port A word
a_ready  out  1  port A word accepted this cycle when a_valid & a_ready
b_valid  in  1  port B has a word
b_data  in  16  port B word
b_ready  out  1  port B word accepted this cycle when b_valid & b_ready
out_valid  out  1  output word valid
out_data  out  16  registered mux output
out_ready  in  1  consumer accepts when out_valid & out_ready
sel  out  1  mux select: 0=A, 1=B; equals current/last owner
busy  out  1  high in OWN_A or OWN_B

Behaviour:
- Decided interface: one clock (clk); reset rst_n is synchronous and active-low. All state changes on the rising edge of clk.
- Reset values: state=IDLE, sel=0, last=1 (A wins the first tie), burst_cnt=0, out_valid=0, out_data=0, a_ready=b_ready=0, busy=0.
- load = !out_valid | out_ready (combinational; the output stage can take a word).
- Ready outputs are combinational: a_ready = (state==OWN_A) & load; b_ready = (state==OWN_B) & load. A non-owner port's ready is always 0. Both readys are 0 in IDLE.
- A beat is x_valid & x_ready. On a beat: out_data <= (sel ? b_data : a_data), out_valid <= 1, burst_cnt += 1.
- If there is no beat and out_ready=1: out_valid <= 0 and out_data holds its value.
- States:
  - IDLE: arbitration only, no transfer.
    - a_valid & b_valid -> OWN_(!last).
    - Only one port valid -> OWN_(that port).
    - Neither valid -> stay in IDLE.
    - On entry to OWN_x: sel <= x, last <= x, burst_cnt <= 0.
  - OWN_x: the owner may transfer. Evaluate in this priority order:
    1. Owner x_valid=0 and other port valid -> OWN_other, burst_cnt <= 0.
    2. Owner x_valid=0 and other port not valid -> IDLE; sel holds its value.
    3. Beat occurs and burst_cnt+1 == MAX_BURST and other port valid -> OWN_other, burst_cnt <= 0.
    4. Beat occurs and burst_cnt+1 == MAX_BURST and other port idle -> stay in OWN_x, burst_cnt <= 0 (a new burst starts).
    5. Otherwise -> stay in OWN_x.
- Handover between owners costs 0 bubble cycles. Only the path through IDLE adds a cycle.
- Latency: valid asserted in IDLE -> out_valid high 2 edges later. Back-to-back beats from the owner give 1 word/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, both readys are 0, and state, burst_cnt and out_data hold. Ownership does not change during the stall unless the owner drops valid.
- The owner dropping valid mid-burst releases the mux immediately; the partial burst is not carried over.
- Reset mid-operation: the word in the output register is discarded, all registers return to their reset values, and no ready is asserted in the reset cycle.
- The block does no data arithmetic; the output word is exactly the selected 16-bit input.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with no valids -> out_valid=0, sel=0, busy=0, a_ready=b_ready=0 for 5 cycles.
- Single port A: a_valid=1, a_data=16'h0C3A, out_ready=1 -> a_ready=1 from cycle 1, out_valid=1 and out_data=16'h0C3A at cycle 2, sel=0.
- Tie and round-robin: a_valid=b_valid=1 continuously, a_data=16'hAAAA, b_data=16'h5555, out_ready=1, MAX_BURST=4 -> out_data sequence AAAA x4, 5555 x4, AAAA x4, with no bubble at handovers and sel toggling every 4 beats.
- Backpressure: mid-burst out_ready=0 for 3 cycles -> out_valid=1 and out_data stable, a_ready=0, burst_cnt frozen; after release the burst resumes and stays at 4 beats total.
- Early release: A owns the mux, a_valid drops after 2 beats, b_valid=1, b_data=16'h1234 -> state goes to OWN_B next edge, sel=1, out_data=16'h1234 one cycle later.
- Reset mid-burst: rst_n=0 for 1 cycle while out_valid=1 -> next edge out_valid=0, state=IDLE, sel=0; the following A/B tie is granted to A.

Source files
------------

// File: rtl/mux16_arbiter.sv
// -----------------------------------------------------------------------------
// mux16_arbiter
//
// Two-requester round-robin arbiter that owns a shared 16-bit 2:1 word mux.
// The winning port streams words through a one-entry registered output stage.
// A burst limit stops one port from holding the mux for more than MAX_BURST
// consecutive beats while the other port is waiting.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous, active-low reset
//   a_valid    in   port A has a word
//   a_data     in   port A word
//   a_ready    out  port A word accepted when a_valid & a_ready
//   b_valid    in   port B has a word
//   b_data     in   port B word
//   b_ready    out  port B word accepted when b_valid & b_ready
//   out_valid  out  output word valid
//   out_data   out  registered mux output
//   out_ready  in   consumer accepts when out_valid & out_ready
//   sel        out  mux select, 0=A 1=B; current or last owner
//   busy       out  high while a port owns the mux
// -----------------------------------------------------------------------------
module mux16_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;

    logic               load;
    logic               beat;
    logic               own_b;
    logic               owner_valid;
    logic               other_valid;
    logic [CNT_W-1:0]   cnt_inc;

    // The output stage can take a word when it is empty or being drained.
    assign load = !out_valid_q || out_ready;

    // Readys are gated with rst_n so nothing is accepted in a reset cycle,
    // even though the state register still holds an owner until the edge.
    assign a_ready = rst_n && (state_q == OWN_A) && load;
    assign b_ready = rst_n && (state_q == OWN_B) && load;

    assign beat        = (a_valid && a_ready) || (b_valid && b_ready);
    assign own_b       = (state_q == OWN_B);
    assign owner_valid = own_b ? b_valid : a_valid;
    assign other_valid = own_b ? a_valid : b_valid;
    assign cnt_inc     = burst_cnt_q + CNT_W'(1);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    // On a tie the port that did not own last time wins.
                    sel_d       = (a_valid && b_valid) ? !last_q : b_valid;
                    last_d      = sel_d;
                    state_d     = sel_d ? OWN_B : OWN_A;
                    burst_cnt_d = '0;
                end
            end

            OWN_A, OWN_B: begin
                if (!owner_valid) begin
                    // Owner released the mux; any partial burst is dropped.
                    burst_cnt_d = '0;
                    if (other_valid) begin
                        state_d = own_b ? OWN_A : OWN_B;
                        sel_d   = !own_b;
                        last_d  = !own_b;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    if (cnt_inc == MAX_CNT) begin
                        // Burst limit reached: hand over only if the other
                        // port is waiting, otherwise start a fresh burst.
                        burst_cnt_d = '0;
                        if (other_valid) begin
                            state_d = own_b ? OWN_A : OWN_B;
                            sel_d   = !own_b;
                            last_d  = !own_b;
                        end
                    end else begin
                        burst_cnt_d = cnt_inc;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            if (beat) begin
                out_data_q  <= sel_q ? b_data : a_data;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux16_arbiter
//
// Directed bench for mux16_arbiter. Expected output words are queued when the
// stimulus that produces them is applied and popped on each output handshake.
// Control outputs are compared against constants at fixed cycles.
// -----------------------------------------------------------------------------
module tb_mux16_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [15:0] b_data;
    logic        b_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        sel;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    mux16_arbiter #(.WIDTH(16), .MAX_BURST(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop for an output handshake happening at the coming edge,
    // then advance one clock and return at the following falling edge.
    task automatic tick();
        logic [15:0] exp_w;
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_data, 16'hxxxx);
            end else begin
                exp_w = exp_q.pop_front();
                check("out_word", out_data, exp_w);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_data    = 16'h0000;
        b_data    = 16'h0000;
        out_ready = 1'b1;

        // Reset then idle.
        tick();
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_data", out_data, 16'h0000);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_out_valid", 16'(out_valid), 16'h0);
            check("idle_sel", 16'(sel), 16'h0);
            check("idle_busy", 16'(busy), 16'h0);
            check("idle_rdy", {14'h0, a_ready, b_ready}, 16'h0);
        end

        // Tie and round-robin: A wins first, 4 beats each, no bubbles.
        a_valid = 1'b1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_data = 16'h5555;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hAAAA);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h5555);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hAAAA);
        #1;
        check("rr_idle_no_ready", {14'h0, a_ready, b_ready}, 16'h0);
        tick();
        check("rr_first_sel", 16'(sel), 16'h0);
        check("rr_first_busy", 16'(busy), 16'h1);
        for (int e = 2; e <= 13; e++) begin
            tick();
            check("rr_no_bubble", 16'(out_valid), 16'h1);
            check("rr_sel", 16'(sel), 16'(((e - 1) / 4) % 2));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("rr_drain_busy", 16'(busy), 16'h0);
        check("rr_drain_valid", 16'(out_valid), 16'h0);
        check("rr_queue_empty", 16'(exp_q.size()), 16'h0);

        // Single port A: ready one cycle in, data two edges after valid.
        do_reset();
        a_valid = 1'b1; a_data = 16'h0C3A;
        exp_q.push_back(16'h0C3A);
        #1;
        check("single_a_ready0", 16'(a_ready), 16'h0);
        tick();
        check("single_a_ready1", 16'(a_ready), 16'h1);
        check("single_out_valid1", 16'(out_valid), 16'h0);
        tick();
        check("single_out_valid2", 16'(out_valid), 16'h1);
        check("single_out_data", out_data, 16'h0C3A);
        check("single_sel", 16'(sel), 16'h0);
        a_valid = 1'b0;
        tick();
        check("single_release_busy", 16'(busy), 16'h0);
        check("single_release_valid", 16'(out_valid), 16'h0);
        check("single_hold_data", out_data, 16'h0C3A);

        // Backpressure mid-burst: burst still ends after 4 beats total.
        do_reset();
        a_valid = 1'b1; a_data = 16'hC0DE;
        b_valid = 1'b1; b_data = 16'h5A5A;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hC0DE);
        exp_q.push_back(16'h5A5A);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        check("bp_a_ready_low", 16'(a_ready), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out_valid", 16'(out_valid), 16'h1);
            check("bp_out_data", out_data, 16'hC0DE);
            check("bp_rdy", {14'h0, a_ready, b_ready}, 16'h0);
            check("bp_sel", 16'(sel), 16'h0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_resume_sel", 16'(sel), 16'h0);
        tick();
        check("bp_handover_sel", 16'(sel), 16'h1);
        check("bp_b_ready", 16'(b_ready), 16'h1);
        tick();
        check("bp_b_word", out_data, 16'h5A5A);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("bp_idle", 16'(busy), 16'h0);
        check("bp_queue_empty", 16'(exp_q.size()), 16'h0);

        // Early release: A drops valid after 2 beats, B takes over at once.
        do_reset();
        a_valid = 1'b1; a_data = 16'h7E57;
        b_valid = 1'b1; b_data = 16'h1234;
        exp_q.push_back(16'h7E57);
        exp_q.push_back(16'h7E57);
        exp_q.push_back(16'h1234);
        tick();
        tick();
        check("er_b_not_owner", 16'(b_ready), 16'h0);
        tick();
        a_valid = 1'b0;
        tick();
        check("er_sel", 16'(sel), 16'h1);
        check("er_busy", 16'(busy), 16'h1);
        check("er_b_ready", 16'(b_ready), 16'h1);
        tick();
        check("er_out_valid", 16'(out_valid), 16'h1);
        check("er_out_data", out_data, 16'h1234);
        b_valid = 1'b0;
        tick();
        check("er_idle", 16'(busy), 16'h0);
        check("er_queue_empty", 16'(exp_q.size()), 16'h0);

        // Reset mid-burst: output word discarded, next tie goes to A.
        do_reset();
        a_valid = 1'b1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_data = 16'h5555;
        tick();
        tick();
        check("mr_out_valid_pre", 16'(out_valid), 16'h1);
        rst_n = 1'b0;
        #1;
        check("mr_rdy_in_reset", {14'h0, a_ready, b_ready}, 16'h0);
        tick();
        check("mr_out_valid", 16'(out_valid), 16'h0);
        check("mr_busy", 16'(busy), 16'h0);
        check("mr_sel", 16'(sel), 16'h0);
        rst_n = 1'b1;
        exp_q.push_back(16'hAAAA);
        tick();
        check("mr_tie_sel", 16'(sel), 16'h0);
        check("mr_tie_rdy", {14'h0, a_ready, b_ready}, 16'h2);
        tick();
        check("mr_tie_word", out_data, 16'hAAAA);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("mr_queue_empty", 16'(exp_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
